// File: rtl/edge_pattern_generator.sv
// edge_pattern_generator
//
// Turns rise / fall / pulse requests into a clean single-bit level. Once an
// edge is made, the level is held for at least Neff = max(N,1) cycles before
// the next edge. A pulse request inverts the level for exactly Neff cycles
// and then restores it on its own. Used as a self-test and trigger-stimulus
// source for sampled logic-analyser inputs.
//
// Ports:
//   i_clk         system clock
//   i_reset       synchronous reset, active-high
//   i_rise        request a rising edge (one-cycle strobe)
//   i_fall        request a falling edge (one-cycle strobe)
//   i_pulse       request an excursion of Neff cycles, then return automatically
//   i_min_cycles  N, the minimum number of cycles between edges, sampled on accept
//   o_signal      generated level (registered)
//   o_busy        high while new requests cannot be accepted
//   o_rise_done   one-cycle pulse in the first cycle o_signal reads 1
//   o_fall_done   one-cycle pulse in the first cycle o_signal reads 0
//   o_drop        one-cycle pulse: a request was discarded
//
// Build option:
//   PENDING_REQ_EN  when defined, a one-deep slot holds the first request that
//                   arrives while busy and executes it in the next READY cycle.
//                   When undefined, every request made while busy is dropped.

module edge_pattern_generator #(
    parameter int   CNT_W      = 8,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rise,
    input  logic             i_fall,
    input  logic             i_pulse,
    input  logic [CNT_W-1:0] i_min_cycles,
    output logic             o_signal,
    output logic             o_busy,
    output logic             o_rise_done,
    output logic             o_fall_done,
    output logic             o_drop
);

    typedef enum logic [1:0] {
        READY = 2'd0,
        HOLD  = 2'd1,
        PULSE = 2'd2
    } state_t;

    // Requests encoded in READY priority order.
    typedef enum logic [2:0] {
        REQ_NONE   = 3'd0,
        REQ_PULSE  = 3'd1,
        REQ_TOGGLE = 3'd2,
        REQ_RISE   = 3'd3,
        REQ_FALL   = 3'd4
    } req_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] n_reg, n_reg_nx;
    logic             sig_nx;
    logic             drop_nx;
    logic [CNT_W-1:0] neff;
    logic             any_req;
    req_t             in_req;
    req_t             exec_req;
    logic             busy;

`ifdef PENDING_REQ_EN
    logic pend_vld, pend_vld_nx;
    req_t pend_req, pend_req_nx;
`endif

    // A hold time of 0 behaves like 1: edges may still come every cycle.
    function automatic logic [CNT_W-1:0] eff_cycles(input logic [CNT_W-1:0] n);
        return (n == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : n;
    endfunction

    function automatic req_t encode_req(input logic p, input logic r, input logic f);
        if (p)           return REQ_PULSE;
        else if (r && f) return REQ_TOGGLE;
        else if (r)      return REQ_RISE;
        else if (f)      return REQ_FALL;
        else             return REQ_NONE;
    endfunction

    assign neff    = eff_cycles(i_min_cycles);
    assign any_req = i_pulse | i_rise | i_fall;
    assign in_req  = encode_req(i_pulse, i_rise, i_fall);

`ifdef PENDING_REQ_EN
    // READY with a pending request still counts as busy: that cycle is spent
    // executing the stored request instead of the live inputs.
    assign busy     = (state != READY) || pend_vld;
    assign exec_req = (state != READY) ? REQ_NONE : (pend_vld ? pend_req : in_req);
`else
    assign busy     = (state != READY);
    assign exec_req = (state != READY) ? REQ_NONE : in_req;
`endif

    assign o_busy = busy;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        n_reg_nx = n_reg;
        sig_nx   = o_signal;
        drop_nx  = 1'b0;
`ifdef PENDING_REQ_EN
        pend_vld_nx = pend_vld;
        pend_req_nx = pend_req;
`endif

        unique case (state)
            READY: begin
                case (exec_req)
                    REQ_PULSE: begin
                        sig_nx   = ~o_signal;
                        cnt_nx   = neff - 1'b1;
                        n_reg_nx = neff;
                        state_nx = PULSE;
                    end
                    REQ_TOGGLE: begin
                        sig_nx   = ~o_signal;
                        cnt_nx   = neff - 1'b1;
                        state_nx = (neff > 1) ? HOLD : READY;
                    end
                    REQ_RISE: begin
                        // Rise while already high is a no-op, not a drop.
                        if (!o_signal) begin
                            sig_nx   = 1'b1;
                            cnt_nx   = neff - 1'b1;
                            state_nx = (neff > 1) ? HOLD : READY;
                        end
                    end
                    REQ_FALL: begin
                        if (o_signal) begin
                            sig_nx   = 1'b0;
                            cnt_nx   = neff - 1'b1;
                            state_nx = (neff > 1) ? HOLD : READY;
                        end
                    end
                    default: ;
                endcase
            end
            HOLD: begin
                // cnt was loaded with Neff-1; leaving at 1 keeps busy for
                // Neff-1 cycles so the level is stable for Neff cycles.
                if (cnt <= 1) begin
                    cnt_nx   = '0;
                    state_nx = READY;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    sig_nx   = ~o_signal;
                    cnt_nx   = n_reg - 1'b1;
                    state_nx = (n_reg > 1) ? HOLD : READY;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = READY;
        endcase

`ifdef PENDING_REQ_EN
        // The stored request is consumed in this READY cycle.
        if (state == READY && pend_vld) pend_vld_nx = 1'b0;
        if (busy && any_req) begin
            if (!pend_vld || state == READY) begin
                pend_vld_nx = 1'b1;
                pend_req_nx = in_req;
            end else begin
                drop_nx = 1'b1;
            end
        end
`else
        drop_nx = busy && any_req;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= READY;
            cnt         <= '0;
            o_signal    <= INIT_LEVEL;
            o_rise_done <= 1'b0;
            o_fall_done <= 1'b0;
            o_drop      <= 1'b0;
`ifdef PENDING_REQ_EN
            pend_vld    <= 1'b0;
            pend_req    <= REQ_NONE;
`endif
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            o_signal    <= sig_nx;
            o_rise_done <= sig_nx & ~o_signal;
            o_fall_done <= ~sig_nx & o_signal;
            o_drop      <= drop_nx;
`ifdef PENDING_REQ_EN
            pend_vld    <= pend_vld_nx;
            pend_req    <= pend_req_nx;
`endif
        end
    end

    // Pulse width register only matters while in PULSE; it is always written
    // on entry, so it needs no reset.
    always_ff @(posedge i_clk) begin
        n_reg <= n_reg_nx;
    end

endmodule

// File: doc/edge_pattern_generator.md
Name: edge_pattern_generator

Overview:
Drives a single-bit output level from edge/pulse requests. It is the inverse of the capture-side edge detector: that block turns a level into rise/fall pulses, this one turns rise/fall/pulse requests into a clean level with a guaranteed minimum hold time between edges. Used as the ILA self-test / trigger-stimulus source feeding sampled signal inputs.

Parameters:
CNT_W, 8, width of hold-time counter and i_min_cycles
INIT_LEVEL, 0, o_signal value after reset

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous reset, active-high
i_rise  input  1  request rising edge (one-cycle strobe)
i_fall  input  1  request falling edge (one-cycle strobe)
i_pulse  input  1  request excursion: invert level for N cycles, then return automatically
i_min_cycles  input  CNT_W  N = minimum cycles between edges; sampled when a request is accepted
o_signal  output  1  generated level (registered)
o_busy  output  1  high while requests are not accepted
o_rise_done  output  1  one-cycle pulse coincident with the cycle o_signal first reads 1
o_fall_done  output  1  one-cycle pulse coincident with the cycle o_signal first reads 0
o_drop  output  1  one-cycle pulse: a request was discarded

Behaviour:
- One clock, i_clk. Reset is synchronous, active-high on i_reset. It overrides everything: o_signal=INIT_LEVEL, state=READY, cnt=0, pending cleared, o_busy=0, all pulse outputs 0.
- Neff = max(N,1). Outputs are registered. A request accepted in cycle t changes o_signal in t+1 (latency 1).
- States: READY, HOLD, PULSE.
- READY (o_busy=0), evaluated in priority order:
  - i_pulse: toggle o_signal; cnt<=Neff-1; latch Neff into n_reg; go PULSE.
  - else i_rise&i_fall: toggle o_signal.
  - else i_rise while o_signal=0, or i_fall while o_signal=1: set the level.
  - Then cnt<=Neff-1; go HOLD if Neff>1, else stay READY.
  - i_rise while already 1, or i_fall while already 0: ignored. No edge, no drop.
- HOLD (o_busy=1): cnt decrements each cycle. When cnt reaches 0, return to READY. The level stays stable for exactly Neff cycles before the next possible edge. Busy lasts Neff-1 cycles.
- PULSE (o_busy=1): cnt decrements. When it is 0, toggle o_signal back (return edge); cnt<=n_reg-1; go HOLD if n_reg>1, else READY. The excursion width is exactly Neff cycles. i_min_cycles changes during PULSE are ignored.
- o_rise_done/o_fall_done fire for every edge of o_signal, including pulse return edges. They never fire both in the same cycle.
- Any asserted request while o_busy=1 is handled per Optional Feature. Without the feature it yields o_drop=1 in the next cycle.
- Counter arithmetic: unsigned CNT_W. No wrap, because cnt is loaded only at accept time and stops at 0. N=2^CNT_W-1 is legal.
- Reset mid-HOLD or mid-PULSE: the excursion is aborted, o_signal=INIT_LEVEL next cycle, and no done pulse is emitted.

Optional Feature:
Macro PENDING_REQ_EN.
- Defined:
  - A one-deep pending slot stores the first request arriving while busy. If several strobes arrive in the same cycle, they are stored encoded by READY priority.
  - The pending request executes in the first READY cycle, in place of that cycle's inputs. Its relevance is evaluated at execution time.
  - A same-cycle new request refills the slot.
  - Any request arriving while the slot is full gives o_drop.
  - o_busy also stays high in READY cycles while the pending request executes.
- Undefined: no slot. Every request while busy is dropped with o_drop.

Test Plan:
- Reset with INIT_LEVEL=0; i_rise at t with N=3 -> o_signal=1 at t+1, o_rise_done at t+1, o_busy high t+1..t+2, READY at t+3.
- i_pulse with N=4 from level 0 -> o_signal 1 for exactly 4 cycles, then 0; o_rise_done then o_fall_done 4 cycles apart; o_busy clear 3 cycles after the return edge.
- N=0 and N=1: i_rise, i_fall on consecutive cycles -> edges on consecutive cycles, o_busy never high.
- i_fall while busy in HOLD -> no define: o_drop pulse, level unchanged. With PENDING_REQ_EN: fall executes in the first READY cycle, and a second request while the slot is full gives o_drop.
- i_rise & i_fall together at level 1 -> toggles to 0. i_rise at level 1 -> no edge, no drop.
- i_reset asserted mid-PULSE (N=10, cycle 5) -> o_signal=INIT_LEVEL next cycle, o_busy=0, no done pulse; a new request is accepted right after reset releases.
